writeback_queue: RTL
====================

# writeback_queue

Write-side front end of the 32×32 register bank. It accepts writeback results from the ALU and the load path over valid/ready handshakes and buffers them in an in-order FIFO. It drains one entry per cycle into the bank's single write port, and tells decode whether a source register still has a pending write, forwarding the youngest pending value.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- DATA_WIDTH, 32, writeback data width
- ADDR_WIDTH, 5, register index width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ld_valid_i  in  1  load result valid
- ld_rd_i  in  ADDR_WIDTH  load destination register
- ld_data_i  in  DATA_WIDTH  load data
- ld_ready_o  out  1  load result accepted this cycle when high with valid
- alu_valid_i  in  1  ALU result valid
- alu_rd_i  in  ADDR_WIDTH  ALU destination register
- alu_data_i  in  DATA_WIDTH  ALU data
- alu_ready_o  out  1  ALU result accepted this cycle when high with valid
- wr_en_o  out  1  write enable to register bank
- rd_addr_o  out  ADDR_WIDTH  write address to register bank
- data_o  out  DATA_WIDTH  write data to register bank
- rs1_addr_i, rs2_addr_i  in  ADDR_WIDTH  decode source indices
- rs1_pending_o, rs2_pending_o  out  1  a queued entry targets that source
- rs1_fwd_o, rs2_fwd_o  out  DATA_WIDTH  data of youngest matching entry; 0 when not pending
- count_o  out  $clog2(DEPTH)+1  occupied entries

## Operation
- FIFO: head/tail pointers, $clog2(DEPTH) bits, wrap modulo DEPTH; count tracks occupancy 0..DEPTH.
- Arbitration: at most one enqueue per cycle. Load has fixed priority.
  - ld_ready_o = (count < DEPTH).
  - alu_ready_o = (count < DEPTH) && !ld_valid_i.
- Transfer happens when valid && ready. A transfer with rd == 0 is accepted (ready honoured) but not stored; count is unchanged.
- Drain: whenever count > 0, the head entry is presented to the bank. The bank always accepts, so the head pops at every edge while non-empty.
- Simultaneous push and pop: count unchanged, both pointers advance.
- When full, a pop occurs at the edge but ready stays low that cycle. No push-when-full bypass.
- Hazard lookup: combinational over all valid entries. Entries are ordered from head (oldest) to tail−1 (youngest).
  - rsN_pending_o = 1 if any valid entry has rd == rsN_addr_i and rsN_addr_i ≠ 0.
  - rsN_fwd_o = data of the youngest such entry.
  - The head entry being written this cycle still counts as pending.
- Data is never modified; widths pass straight through.

## Timing
- Reset (rst_n low at an edge): count = 0, head = tail = 0.
  - Outputs after reset: wr_en_o 0, rd_addr_o 0, data_o 0, both pending 0, both fwd 0, count_o 0. ld_ready_o 1; alu_ready_o = !ld_valid_i.
  - Reset mid-operation discards all queued entries with no bank writes.
- wr_en_o = (count > 0). rd_addr_o and data_o are driven from the head entry and are 0 when empty. All three come from registered state, with no combinational path from the inputs.
- Latency: a result accepted at edge N gives wr_en_o high in cycle N→N+1 if the queue was empty before edge N. The bank commits it at edge N+1.
- With k entries ahead, the commit happens at edge N+1+k.
- Throughput: one writeback per cycle sustained. The ALU stalls only in cycles where a load is valid or the queue is full.
- The pending/fwd outputs are combinational from rsN_addr_i and registered queue state.

## Structure
- A shared package holds DATA_WIDTH/ADDR_WIDTH defaults and a wb_entry struct {rd, data}.
- One sub-module: wb_fifo, a parameterised circular buffer with push/pop/count that exposes all entries plus per-entry valid for the hazard scan.
- The top level contains the arbiter and the hazard/forward scan.

## Test plan
1. Reset with ld_valid_i = 0 and alu_valid_i = 0 -> wr_en_o 0, count_o 0, ld_ready_o 1, alu_ready_o 1, fwd outputs 0.
2. Push ALU rd=3, data=0xDEADBEEF at edge N into an empty queue.
   - Cycle after N: wr_en_o 1, rd_addr_o 3, data_o 0xDEADBEEF.
   - Cycle after N+1: wr_en_o 0.
3. Load rd=5/0x11 and ALU rd=6/0x22 valid in the same cycle.
   - Result: ld_ready_o 1, alu_ready_o 0. Load enqueued first; ALU enqueued next cycle.
   - Bank sees rd 5 then rd 6 on consecutive cycles.
4. Push rd=7/0xA, then rd=7/0xB on back-to-back edges, with rs1_addr_i = 7 and rs2_addr_i = 0.
   - While both are queued: rs1_pending_o 1, rs1_fwd_o 0xB.
   - Always: rs2_pending_o 0.
5. Push ALU rd=0 with data 0x1234 -> alu_ready_o 1, count_o stays 0, wr_en_o stays 0.
6. DEPTH=4: hold ld_valid_i high with distinct rd for 6 cycles.
   - Writes appear in order, one per cycle; count never exceeds 4; no entry is lost or duplicated.
   - rst_n low mid-stream -> next cycle count_o 0, wr_en_o 0.

Source files
------------

// File: rtl/writeback_queue_pkg.sv
// Shared defaults and the queued writeback entry layout for the register-bank write front end.
package writeback_queue_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DEPTH_DEF      = 4;

    // Packed as {rd, data}; wb_fifo stores entries in this same bit order.
    typedef struct packed {
        logic [ADDR_WIDTH_DEF-1:0] rd;
        logic [DATA_WIDTH_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_queue_fifo.sv
// Circular buffer holding packed writeback entries; exposes every slot in age order for the hazard scan.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_data_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic [DEPTH-1:0][WIDTH-1:0]  entries_o,
    output logic [DEPTH-1:0]             valid_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PW-1:0]               head_q, head_d;
    logic [PW-1:0]               tail_q, tail_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        do_push, do_pop;

    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        // A full queue refuses the push even when it pops the same edge.
        do_push = push_i && (count_q < CW'(DEPTH));
        head_d  = head_q + PW'(do_pop);
        tail_d  = tail_q + PW'(do_push);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            mem_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (do_push) begin
                mem_q[tail_q] <= push_data_i;
            end
        end
    end

    // Slot 0 is the oldest entry, slot count-1 the youngest.
    always_comb begin
        entries_o = '0;
        valid_o   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entries_o[i] = mem_q[head_q + PW'(i)];
            valid_o[i]   = CW'(i) < count_q;
        end
    end

    assign head_data_o = mem_q[head_q];
    assign count_o     = count_q;

endmodule

// File: rtl/writeback_queue.sv
// Load/ALU writeback arbiter feeding an in-order queue that drains into the register bank, with source hazard lookup.
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ld_valid_i,
    input  logic [ADDR_WIDTH-1:0]     ld_rd_i,
    input  logic [DATA_WIDTH-1:0]     ld_data_i,
    output logic                      ld_ready_o,
    input  logic                      alu_valid_i,
    input  logic [ADDR_WIDTH-1:0]     alu_rd_i,
    input  logic [DATA_WIDTH-1:0]     alu_data_i,
    output logic                      alu_ready_o,
    output logic                      wr_en_o,
    output logic [ADDR_WIDTH-1:0]     rd_addr_o,
    output logic [DATA_WIDTH-1:0]     data_o,
    input  logic [ADDR_WIDTH-1:0]     rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0]     rs2_addr_i,
    output logic                      rs1_pending_o,
    output logic                      rs2_pending_o,
    output logic [DATA_WIDTH-1:0]     rs1_fwd_o,
    output logic [DATA_WIDTH-1:0]     rs2_fwd_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    logic                       not_full;
    logic                       ld_fire, alu_fire;
    logic                       push;
    logic [EW-1:0]              push_entry;
    logic                       not_empty;
    logic [EW-1:0]              head_entry;
    logic [CW-1:0]              fifo_count;
    logic [DEPTH-1:0][EW-1:0]   entries;
    logic [DEPTH-1:0]           entry_valid;

    assign not_full    = fifo_count < CW'(DEPTH);
    assign ld_ready_o  = not_full;
    assign alu_ready_o = not_full && !ld_valid_i;
    assign ld_fire     = ld_valid_i && ld_ready_o;
    assign alu_fire    = alu_valid_i && alu_ready_o;

    // Writes to x0 complete the handshake but are dropped here.
    always_comb begin
        push       = 1'b0;
        push_entry = {alu_rd_i, alu_data_i};
        if (ld_fire) begin
            push       = ld_rd_i != '0;
            push_entry = {ld_rd_i, ld_data_i};
        end else if (alu_fire) begin
            push       = alu_rd_i != '0;
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (not_empty),
        .head_data_o (head_entry),
        .count_o     (fifo_count),
        .entries_o   (entries),
        .valid_o     (entry_valid)
    );

    assign not_empty = fifo_count != '0;
    assign wr_en_o   = not_empty;
    assign rd_addr_o = not_empty ? head_entry[EW-1:DATA_WIDTH] : '0;
    assign data_o    = not_empty ? head_entry[DATA_WIDTH-1:0] : '0;
    assign count_o   = fifo_count;

    // Scanning oldest to youngest lets the youngest match overwrite earlier ones.
    always_comb begin
        rs1_pending_o = 1'b0;
        rs2_pending_o = 1'b0;
        rs1_fwd_o     = '0;
        rs2_fwd_o     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (rs1_addr_i != '0) && (entries[i][EW-1:DATA_WIDTH] == rs1_addr_i)) begin
                rs1_pending_o = 1'b1;
                rs1_fwd_o     = entries[i][DATA_WIDTH-1:0];
            end
            if (entry_valid[i] && (rs2_addr_i != '0) && (entries[i][EW-1:DATA_WIDTH] == rs2_addr_i)) begin
                rs2_pending_o = 1'b1;
                rs2_fwd_o     = entries[i][DATA_WIDTH-1:0];
            end
        end
    end

endmodule
